// File: rtl/keycode_led_queue.sv
`default_nettype none
// ============================================================================
//  Module      : keycode_led_queue
//  Description : Queues single-cycle keycode strobes in a small FIFO and shows
//                each code on the LEDs for HOLD_CYCLES clocks, in arrival
//                order. Provides display modes, overflow accounting and an
//                optional key-release filter (`KEYCODE_RELEASE_FILTER_EN`).
//  Revision    : 1.0 - initial release
// ============================================================================
module keycode_led_queue #(
    parameter int             CODE_W       = 16,
    parameter int             LED_W        = 6,
    parameter int             DEPTH        = 4,
    parameter int             HOLD_CYCLES  = 27000000,
    parameter logic [LED_W-1:0] IDLE_PATTERN = 6'b110011,
    parameter bit             ACTIVE_LOW   = 1'b1,
    parameter int             RELEASE_BIT  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CODE_W-1:0] code_in,
    input  logic              code_valid,
    input  logic [1:0]        mode,
    output logic [LED_W-1:0]  led,
    output logic              busy,
    output logic              overflow,
    output logic [7:0]        drop_count
);

    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_CNT_W  = $clog2(DEPTH + 1);
    localparam int c_HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int c_SHOW_W = 2 * LED_W - 2;
    localparam int c_EXT_W  = (CODE_W > c_SHOW_W) ? CODE_W : c_SHOW_W;

    localparam logic [c_HOLD_W-1:0] c_HOLD_RELOAD = c_HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]  c_FULL        = c_CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SHOW = 1'b1
    } state_t;

    // FIFO storage and bookkeeping
    logic [CODE_W-1:0]   mem_q [DEPTH];
    logic [c_PTR_W-1:0]  wr_ptr_q;
    logic [c_PTR_W-1:0]  rd_ptr_q;
    logic [c_CNT_W-1:0]  count_q;

    // Display FSM state
    state_t              state_q;
    logic [CODE_W-1:0]   disp_q;
    logic                shown_q;
    logic [c_HOLD_W-1:0] hold_q;

    // Drop accounting
    logic                overflow_q;
    logic [7:0]          drop_count_q;

    logic                w_accept;
    logic                w_nonempty;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic [c_EXT_W-1:0]  w_ext;
    logic [LED_W-1:0]    w_led_logic;
    logic                w_unused_bits;

`ifdef KEYCODE_RELEASE_FILTER_EN
    // Key-release codes never reach the queue and are not drops.
    assign w_accept = code_valid & ~code_in[RELEASE_BIT];
`else
    assign w_accept = code_valid;
`endif

    // The FSM pops whenever it is free to show a new code and one is waiting.
    assign w_nonempty = (count_q != '0);
    assign w_pop      = w_nonempty & ((state_q == S_IDLE) | (hold_q == '0));
    // A simultaneous pop frees a slot, so a full FIFO still accepts the push.
    assign w_push     = w_accept & ((count_q != c_FULL) | w_pop);
    assign w_drop     = w_accept & (count_q == c_FULL) & ~w_pop;

    // FIFO payload; no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= code_in;
        end
    end

    // FIFO pointers and occupancy counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + c_CNT_W'(1);
                2'b01:   count_q <= count_q - c_CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Display FSM: load the head, hold it, then chain to the next or go idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            disp_q  <= '0;
            shown_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_pop) begin
                        disp_q  <= mem_q[rd_ptr_q];
                        shown_q <= 1'b1;
                        hold_q  <= c_HOLD_RELOAD;
                        state_q <= S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (hold_q != '0) begin
                        hold_q <= hold_q - c_HOLD_W'(1);
                    end else if (w_pop) begin
                        disp_q <= mem_q[rd_ptr_q];
                        hold_q <= c_HOLD_RELOAD;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else if (w_drop) begin
            overflow_q <= 1'b1;
            if (drop_count_q != 8'hFF) begin
                drop_count_q <= drop_count_q + 8'd1;
            end
        end
    end

    // Zero-extend the shown code so mode 1 reads 0 past the code width.
    assign w_ext         = c_EXT_W'(disp_q);
    assign w_unused_bits = ^w_ext;

    // Logical LED pattern per display mode, then output polarity.
    always_comb begin
        w_led_logic = '0;
        case (mode)
            2'd0: begin
                w_led_logic = shown_q ? {1'b1, w_ext[LED_W-2:0]} : IDLE_PATTERN;
            end
            2'd1: begin
                w_led_logic = shown_q ? {1'b1, w_ext[c_SHOW_W-1:LED_W-1]} : IDLE_PATTERN;
            end
            2'd2: begin
                for (int i = 0; i < LED_W; i++) begin
                    w_led_logic[i] = (i < int'(count_q));
                end
            end
            default: begin
                w_led_logic = '0;
            end
        endcase
        led = ACTIVE_LOW ? ~w_led_logic : w_led_logic;
    end

    assign busy       = (state_q == S_SHOW);
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_keycode_led_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keycode_led_queue
//  Description : Self-checking bench for keycode_led_queue against a
//                queue-based reference model of the display behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keycode_led_queue;

    localparam int HOLD = 4;
    localparam int QDEP = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] code_in = '0;
    logic        code_valid = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [5:0]  led;
    logic        busy;
    logic        overflow;
    logic [7:0]  drop_count;

    int checks = 0;
    int passes = 0;

    // Reference model state
    logic [15:0] mq[$];
    logic [15:0] m_disp;
    bit          m_shown;
    int          m_remaining;   // display cycles left for the current code
    bit          m_ovf;
    int          m_drops;

    keycode_led_queue #(
        .CODE_W(16), .LED_W(6), .DEPTH(QDEP), .HOLD_CYCLES(HOLD),
        .IDLE_PATTERN(6'b110011), .ACTIVE_LOW(1'b1), .RELEASE_BIT(7)
    ) dut (
        .clk(clk), .reset(reset), .code_in(code_in), .code_valid(code_valid),
        .mode(mode), .led(led), .busy(busy), .overflow(overflow),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        m_disp      = '0;
        m_shown     = 1'b0;
        m_remaining = 0;
        m_ovf       = 1'b0;
        m_drops     = 0;
    endtask

    // One clock of the model: a code leaves the queue when the current one is
    // in its final cycle (or nothing is shown); then the arriving code enters.
    task automatic model_step(input logic v, input logic [15:0] c);
        bit acc;
`ifdef KEYCODE_RELEASE_FILTER_EN
        acc = v && !c[7];
`else
        acc = v;
`endif
        if (mq.size() > 0 && m_remaining <= 1) begin
            m_disp      = mq.pop_front();
            m_shown     = 1'b1;
            m_remaining = HOLD;
        end else if (m_remaining > 0) begin
            m_remaining--;
        end
        if (acc) begin
            if (mq.size() < QDEP) mq.push_back(c);
            else begin
                m_ovf = 1'b1;
                if (m_drops < 255) m_drops++;
            end
        end
    endtask

    function automatic logic [5:0] exp_led(input logic [1:0] m);
        int v;
        int n;
        case (m)
            2'd0: v = m_shown ? 32 + (int'(m_disp) % 32) : 51;
            2'd1: v = m_shown ? 32 + ((int'(m_disp) / 32) % 32) : 51;
            2'd2: begin
                n = (mq.size() > 6) ? 6 : mq.size();
                v = (1 << n) - 1;
            end
            default: v = 0;
        endcase
        return ~(6'(v));
    endfunction

    function automatic logic [15:0] exp_vec();
        return {exp_led(mode), (m_remaining > 0), m_ovf, 8'(m_drops)};
    endfunction

    // Drive one clock: inputs stable before the edge, sampled 2 time units after.
    task automatic cycle(input logic v, input logic [15:0] c);
        code_valid = v;
        code_in    = c;
        @(posedge clk);
        model_step(v, c);
        #2;
        code_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] want;
        model_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            #1;
            want = (m < 2) ? 6'b001100 : 6'b111111;
            checks++;
            if ({led, busy, overflow, drop_count} !== {want, 1'b0, 1'b0, 8'd0})
                $display("FAIL reset mode%0d: got led=%b busy=%b ovf=%b dc=%0d want led=%b 0 0 0",
                         m, led, busy, overflow, drop_count, want);
            else passes++;
        end
        mode  = 2'd0;
        reset = 1'b0;
    endtask

    task automatic test_single();
        cycle(1'b1, 16'h0015);
        for (int k = 1; k <= 6; k++) begin
            cycle(1'b0, 16'h0);
            checks++;
            if ({led, busy} !== {6'b001010, (k <= HOLD)})
                $display("FAIL single k=%0d: got led=%b busy=%b want led=001010 busy=%0d",
                         k, led, busy, (k <= HOLD));
            else passes++;
            checks++;
            if ({led, busy, overflow, drop_count} !== exp_vec())
                $display("FAIL single_model k=%0d: got %h want %h",
                         k, {led, busy, overflow, drop_count}, exp_vec());
            else passes++;
        end
    endtask

    task automatic test_overflow();
        for (int k = 1; k <= 7; k++) begin
            cycle(1'b1, 16'(k));
            checks++;
            if ({led, busy, overflow, drop_count} !== exp_vec())
                $display("FAIL overflow_fill k=%0d: got %h want %h",
                         k, {led, busy, overflow, drop_count}, exp_vec());
            else passes++;
        end
        for (int k = 0; k < 28; k++) begin
            cycle(1'b0, 16'h0);
            checks++;
            if ({led, busy, overflow, drop_count} !== exp_vec())
                $display("FAIL overflow_drain k=%0d: got %h want %h",
                         k, {led, busy, overflow, drop_count}, exp_vec());
            else passes++;
        end
        checks++;
        if ({overflow, drop_count, busy} !== {1'b1, 8'd1, 1'b0})
            $display("FAIL overflow_final: got ovf=%b dc=%0d busy=%b want 1 1 0",
                     overflow, drop_count, busy);
        else passes++;
    endtask

    task automatic test_modes();
        cycle(1'b1, 16'h0021);
        cycle(1'b1, 16'h0022);
        cycle(1'b1, 16'h0023);
        cycle(1'b1, 16'h0024);
        mode = 2'd2;
        #1;
        checks++;
        if (led !== 6'b111000) $display("FAIL mode2_thermo: got %b want 111000", led);
        else passes++;
        mode = 2'd3;
        #1;
        checks++;
        if (led !== 6'b111111) $display("FAIL mode3_off: got %b want 111111", led);
        else passes++;
        for (int k = 0; k < 20; k++) begin
            if (k == 6) mode = 2'd1;
            if (k == 12) mode = 2'd0;
            cycle(1'b0, 16'h0);
            checks++;
            if ({led, busy, overflow, drop_count} !== exp_vec())
                $display("FAIL modes k=%0d: got %h want %h",
                         k, {led, busy, overflow, drop_count}, exp_vec());
            else passes++;
        end
    endtask

    task automatic test_release();
        cycle(1'b1, 16'h0015);
        repeat (6) cycle(1'b0, 16'h0);
        cycle(1'b1, 16'h0095);
        cycle(1'b0, 16'h0);
        checks++;
`ifdef KEYCODE_RELEASE_FILTER_EN
        if ({led, busy} !== {6'b001010, 1'b0})
            $display("FAIL release_filtered: got led=%b busy=%b want 001010 0", led, busy);
        else passes++;
`else
        if ({led, busy} !== {6'b001010, 1'b1})
            $display("FAIL release_shown: got led=%b busy=%b want 001010 1", led, busy);
        else passes++;
`endif
        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, 16'h0);
            checks++;
            if ({led, busy, overflow, drop_count} !== exp_vec())
                $display("FAIL release k=%0d: got %h want %h",
                         k, {led, busy, overflow, drop_count}, exp_vec());
            else passes++;
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 16'h0031);
        cycle(1'b1, 16'h0032);   // 0x31 shown from here
        cycle(1'b1, 16'h0033);
        reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({led, busy, overflow, drop_count} !== {6'b001100, 1'b0, 1'b0, 8'd0})
            $display("FAIL reset_mid_async: got led=%b busy=%b ovf=%b dc=%0d want 001100 0 0 0",
                     led, busy, overflow, drop_count);
        else passes++;
        @(posedge clk);
        #2;
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, 16'h0);
            checks++;
            if ({led, busy, drop_count} !== {6'b001100, 1'b0, 8'd0})
                $display("FAIL reset_mid_after k=%0d: got led=%b busy=%b dc=%0d want 001100 0 0",
                         k, led, busy, drop_count);
            else passes++;
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            mode = 2'($urandom_range(0, 3));
            cycle(($urandom_range(0, 2) == 0), 16'($urandom));
            checks++;
            if ({led, busy, overflow, drop_count} !== exp_vec())
                $display("FAIL random k=%0d mode=%0d: got %h want %h",
                         k, mode, {led, busy, overflow, drop_count}, exp_vec());
            else passes++;
        end
    endtask

    task automatic test_saturate();
        mode = 2'd2;
        for (int k = 0; k < 400; k++) begin
            cycle(1'b1, 16'($urandom) & 16'hFF7F);
            checks++;
            if ({led, busy, overflow, drop_count} !== exp_vec())
                $display("FAIL saturate k=%0d: got %h want %h",
                         k, {led, busy, overflow, drop_count}, exp_vec());
            else passes++;
        end
        checks++;
        if ({overflow, drop_count} !== {1'b1, 8'd255})
            $display("FAIL saturate_final: got ovf=%b dc=%0d want 1 255", overflow, drop_count);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_modes();
        test_release();
        test_reset_mid();
        test_random();
        test_saturate();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
